// File: rtl/card_shoe.sv
// Single-deck card shoe: deals 52 cards without replacement, choosing a start
// index from a free-running LFSR and linearly probing a used-card bitmap.
module card_shoe #(
    parameter logic [5:0] SEED = 6'h01
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       NEXT_C,
    input  logic       SHUFFLE,
    output logic [3:0] CARD,
    output logic       NEW_C,
    output logic [5:0] CARDS_LEFT,
    output logic       EMPTY
);

    localparam logic [5:0] SEED_L    = (SEED == 6'h00) ? 6'h01 : SEED;
    localparam logic [5:0] DECK_SIZE = 6'd52;
    localparam logic [5:0] LAST_IDX  = 6'd51;

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        PROBE,
        PRESENT
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  lfsr_q, lfsr_d;
    logic [51:0] used_q, used_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [3:0]  card_q, card_d;
    logic        new_c_q, new_c_d;
    logic [5:0]  left_q, left_d;
    logic        hit;

    // Blackjack value of deck index i: rank 0 is the Ace, ranks 10..12 are faces.
    function automatic logic [3:0] card_value(input logic [5:0] idx);
        logic [5:0] rank;
        if (idx >= 6'd39)      rank = idx - 6'd39;
        else if (idx >= 6'd26) rank = idx - 6'd26;
        else if (idx >= 6'd13) rank = idx - 6'd13;
        else                   rank = idx;
        if (rank == 6'd0)       card_value = 4'd11;
        else if (rank <= 6'd9)  card_value = rank[3:0] + 4'd1;
        else                    card_value = 4'd10;
    endfunction

    assign hit = ~used_q[ptr_q];

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_L;
            used_q  <= '0;
            ptr_q   <= '0;
            card_q  <= '0;
            new_c_q <= 1'b0;
            left_q  <= DECK_SIZE;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            used_q  <= used_d;
            ptr_q   <= ptr_d;
            card_q  <= card_d;
            new_c_q <= new_c_d;
            left_q  <= left_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!SHUFFLE && NEXT_C && (left_q != '0)) state_d = PICK;
            end
            PICK:    state_d = PROBE;
            PROBE: begin
                if (hit) state_d = PRESENT;
            end
            PRESENT: begin
                if (!NEXT_C) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d  = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
        used_d  = used_q;
        ptr_d   = ptr_q;
        card_d  = card_q;
        new_c_d = new_c_q;
        left_d  = left_q;
        unique case (state_q)
            IDLE: begin
                if (SHUFFLE) begin
                    used_d = '0;
                    left_d = DECK_SIZE;
                end
            end
            PICK: begin
                ptr_d = (lfsr_q < DECK_SIZE) ? lfsr_q : lfsr_q - DECK_SIZE;
            end
            PROBE: begin
                if (hit) begin
                    used_d[ptr_q] = 1'b1;
                    card_d        = card_value(ptr_q);
                    left_d        = left_q - 6'd1;
                    new_c_d       = 1'b1;
                end else begin
                    ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + 6'd1;
                end
            end
            PRESENT: begin
                if (!NEXT_C) new_c_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign CARD       = card_q;
    assign NEW_C      = new_c_q;
    assign CARDS_LEFT = left_q;
    assign EMPTY      = (left_q == '0);

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: a deck-level model (used set, LFSR sequence table by
// edge count) predicts each dealt card and its latency.
module tb_card_shoe;

    localparam logic [5:0] SEED = 6'h01;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       NEXT_C;
    logic       SHUFFLE;
    logic [3:0] CARD;
    logic       NEW_C;
    logic [5:0] CARDS_LEFT;
    logic       EMPTY;

    card_shoe #(.SEED(SEED)) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .NEXT_C(NEXT_C),
        .SHUFFLE(SHUFFLE),
        .CARD(CARD),
        .NEW_C(NEW_C),
        .CARDS_LEFT(CARDS_LEFT),
        .EMPTY(EMPTY)
    );

    initial forever #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] seq [63];
    int         ecount;
    bit         used_m [52];
    int         left_m;
    int         hist [12];
    int         card_sum;
    int         last_card;

    typedef struct {
        bit next_c;
        bit shuffle;
        bit exp_new_c;
        int exp_left;
        bit exp_empty;
    } vec_t;
    vec_t vecs[$];

    // Edges since the last reset; the LFSR value after n edges is seq[n % 63].
    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) ecount <= 0;
        else          ecount <= ecount + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int value_of(input int idx);
        int r;
        r = idx % 13;
        if (r == 0) return 11;
        if (r <= 9) return r + 1;
        return 10;
    endfunction

    task automatic clear_deck();
        for (int i = 0; i < 52; i++) used_m[i] = 1'b0;
        left_m = 52;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 12; i++) hist[i] = 0;
        card_sum = 0;
    endtask

    // Called at a negedge with the DUT in IDLE and the deck not empty.
    task automatic deal(input bit keep_high, input int hold, input bit shuf_present);
        int lv, start, idx, coll, n, held_card;
        NEXT_C = 1'b1;
        @(posedge CLOCK); @(negedge CLOCK);
        lv    = int'(seq[ecount % 63]);
        start = (lv < 52) ? lv : lv - 52;
        idx   = start;
        coll  = 0;
        while (used_m[idx] && coll < 52) begin
            idx = (idx + 1) % 52;
            coll++;
        end
        n = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge CLOCK); @(negedge CLOCK);
            n++;
            if (NEW_C) break;
        end
        check("deal_latency", n, 2 + coll);
        check("deal_new_c", int'(NEW_C), 1);
        used_m[idx] = 1'b1;
        left_m--;
        check("deal_card", int'(CARD), value_of(idx));
        check("deal_left", int'(CARDS_LEFT), left_m);
        check("deal_empty", int'(EMPTY), (left_m == 0) ? 1 : 0);
        last_card = int'(CARD);
        held_card = int'(CARD);
        hist[value_of(idx)]++;
        card_sum += value_of(idx);
        if (shuf_present) SHUFFLE = 1'b1;
        repeat (hold) begin
            @(posedge CLOCK); @(negedge CLOCK);
            check("present_new_c", int'(NEW_C), 1);
            check("present_card", int'(CARD), held_card);
            check("present_left", int'(CARDS_LEFT), left_m);
        end
        if (keep_high) return;
        NEXT_C  = 1'b0;
        SHUFFLE = 1'b0;
        @(posedge CLOCK); @(negedge CLOCK);
        check("release_new_c", int'(NEW_C), 0);
        check("release_card_kept", int'(CARD), held_card);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            NEXT_C  = vecs[i].next_c;
            SHUFFLE = vecs[i].shuffle;
            @(posedge CLOCK); @(negedge CLOCK);
            check($sformatf("vec%0d_new_c", i), int'(NEW_C), int'(vecs[i].exp_new_c));
            check($sformatf("vec%0d_left", i), int'(CARDS_LEFT), vecs[i].exp_left);
            check($sformatf("vec%0d_empty", i), int'(EMPTY), int'(vecs[i].exp_empty));
        end
        NEXT_C  = 1'b0;
        SHUFFLE = 1'b0;
    endtask

    initial begin
        logic [5:0] l;
        bit found;
        l = SEED;
        for (int i = 0; i < 63; i++) begin
            seq[i] = l;
            l = {l[4:0], l[5] ^ l[4]};
        end
        for (int i = 0; i < 20; i++) vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 52, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 52, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 52, 1'b0});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b0, 1'b0, 52, 1'b0});

        RESET_N = 1'b0;
        NEXT_C  = 1'b0;
        SHUFFLE = 1'b0;
        clear_deck();
        clear_stats();
        repeat (2) @(negedge CLOCK);
        check("reset_new_c", int'(NEW_C), 0);
        check("reset_card", int'(CARD), 0);
        check("reset_left", int'(CARDS_LEFT), 52);
        check("reset_empty", int'(EMPTY), 0);

        RESET_N = 1'b1;
        deal(1'b0, 1, 1'b0);
        check("first_card", last_card, 3);
        check("first_left", int'(CARDS_LEFT), 51);

        // Wait until the next request's PICK will land on index 2 again.
        found = 1'b0;
        for (int t = 0; t < 70; t++) begin
            l = seq[(ecount + 1) % 63];
            if (l == 6'd2 || l == 6'd54) begin
                found = 1'b1;
                break;
            end
            @(negedge CLOCK);
        end
        check("collision_setup_found", int'(found), 1);
        deal(1'b0, 0, 1'b0);
        check("collision_card", last_card, 4);

        // Asynchronous reset while presenting a card.
        deal(1'b1, 2, 1'b0);
        #3 RESET_N = 1'b0;
        #1;
        check("async_reset_new_c", int'(NEW_C), 0);
        check("async_reset_left", int'(CARDS_LEFT), 52);
        check("async_reset_card", int'(CARD), 0);
        clear_deck();
        clear_stats();
        @(negedge CLOCK);
        RESET_N = 1'b1;
        deal(1'b0, 0, 1'b0);
        check("post_reset_card", last_card, 3);

        deal(1'b0, 3, 1'b1);
        check("shuffle_in_present_left", int'(CARDS_LEFT), 50);

        for (int d = 0; d < 50; d++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLOCK);
            deal(1'b0, $urandom_range(0, 2), 1'b0);
        end
        check("deck_sum", card_sum, 380);
        check("count_11", hist[11], 4);
        check("count_10", hist[10], 16);
        for (int v = 2; v <= 9; v++) check($sformatf("count_%0d", v), hist[v], 4);
        check("deck_left", int'(CARDS_LEFT), 0);
        check("deck_empty", int'(EMPTY), 1);

        run_vecs(0, 22);
        clear_deck();
        deal(1'b0, 0, 1'b0);
        check("after_shuffle_left", int'(CARDS_LEFT), 51);
        run_vecs(23, 26);
        clear_deck();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Upstream dealer stage for the blackjack player controller; supplies its CARD/NEW_C inputs in response to its NEXT_C request.
- Models one 52-card deck dealt without replacement, with pseudo-random selection from a free-running LFSR plus linear probing over a used-card bitmap.
- Reports cards remaining and an empty flag; reshuffles on command.

Parameters:
SEED, 6'h01, LFSR reset value; 0 is illegal and is replaced by 6'h01.

Ports:
CLOCK  input  1  single clock; all state changes on the rising edge.
RESET_N  input  1  asynchronous, active-low reset.
NEXT_C  input  1  card request from the player controller; level-sensitive.
SHUFFLE  input  1  reshuffle command; honoured only in IDLE.
CARD  output  4  dealt card value, 2..11 (Ace = 11, J/Q/K = 10); valid while NEW_C = 1.
NEW_C  output  1  card-present strobe; held until NEXT_C is seen low.
CARDS_LEFT  output  6  undealt cards, 0..52.
EMPTY  output  1  1 when CARDS_LEFT = 0 (combinational).

Behaviour:
- Reset (RESET_N = 0, asynchronous): state IDLE, LFSR = SEED, used[51:0] = 0, ptr = 0, CARD = 0, NEW_C = 0, CARDS_LEFT = 52, EMPTY = 0.
- LFSR: 6-bit Fibonacci, next = {lfsr[4:0], lfsr[5]^lfsr[4]}. Advances on every edge after reset, in every state.
- Card index i (0..51): rank r = i mod 13. r = 0 gives 11; r = 1..9 gives r+1; r = 10..12 gives 10.
- IDLE:
  - SHUFFLE = 1 has priority: clear used, CARDS_LEFT = 52, stay IDLE.
  - Else, if NEXT_C = 1 and CARDS_LEFT > 0: go to PICK.
  - If NEXT_C = 1 and CARDS_LEFT = 0: stay IDLE; NEW_C stays 0, no other change.
- PICK (1 cycle): ptr = lfsr if lfsr < 52, else lfsr - 52, using the pre-update register value. Go to PROBE.
- PROBE:
  - used[ptr] = 0 (hit): set used[ptr], CARD = value(ptr), CARDS_LEFT -= 1, NEW_C = 1, go to PRESENT.
  - Else: ptr = (ptr = 51) ? 0 : ptr+1, stay PROBE.
  - Bounded to at most 52 cycles, because entry requires CARDS_LEFT > 0.
- PRESENT:
  - CARD and NEW_C held stable.
  - When NEXT_C = 0 is sampled: NEW_C = 0, go to IDLE.
  - CARD keeps its last value after NEW_C falls.
- Latency: with first-probe hit, edge k (IDLE samples NEXT_C = 1) goes to PICK, edge k+1 goes to PROBE, edge k+2 sets NEW_C = 1. Each probe collision adds one cycle.
- Handshake with consumer:
  - NEXT_C high, then NEW_C rises.
  - Consumer leaves its request state, so NEXT_C falls.
  - NEW_C falls, and the consumer proceeds.
  - Never two NEW_C pulses per request.
  - A NEXT_C that stays high re-requests only after the return to IDLE.
- SHUFFLE and NEXT_C outside IDLE: SHUFFLE is ignored in PICK/PROBE/PRESENT. NEXT_C is ignored in PICK/PROBE.
- Reset mid-operation (any state, including PRESENT): immediate return to reset values; NEW_C drops asynchronously.
- No card index is ever dealt twice between shuffles.

Test Plan:
- SEED = 1; deassert RESET_N, hold NEXT_C = 1 from the first edge -> NEW_C = 1 after the 3rd edge, CARD = 3 (index 2), CARDS_LEFT = 51. Drop NEXT_C -> NEW_C = 0 one edge later, state IDLE.
- Run 52 full handshakes -> 52 NEW_C pulses, sum of CARD = 380, value 11 seen 4 times, value 10 seen 16 times, values 2..9 seen 4 times each, CARDS_LEFT = 0, EMPTY = 1.
- With EMPTY = 1, raise NEXT_C for 20 cycles -> NEW_C stays 0, CARDS_LEFT stays 0. Then pulse SHUFFLE with NEXT_C = 0 -> CARDS_LEFT = 52, EMPTY = 0, next request deals normally.
- Force a collision: deal index 2 after reset, shuffle not applied, arrange a PICK yielding ptr = 2 -> one extra PROBE cycle, card from index 3 (value 4), NEW_C delayed by exactly one cycle.
- Assert RESET_N = 0 while in PRESENT -> NEW_C = 0 immediately (before the next edge), CARDS_LEFT = 52, CARD = 0. After release, the first deal again yields CARD = 3.
- Hold SHUFFLE = 1 during PRESENT -> ignored, CARDS_LEFT unchanged. Then assert SHUFFLE and NEXT_C together in IDLE -> shuffle wins, no PICK that cycle.
